// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler and block fill engine for a 2-way, 64-set,
// 8-word-per-block cache.
//
// On a miss it latches tag/index/victim/other-way metadata, issues one read
// request per word to main memory, writes each returned word into the victim
// way, then writes the victim metadata {valid=1, lru=0, tag} and marks the
// other way as least recently used.
//
// Handshake: there is no back-pressure. mem_req is a one-cycle request
// carrying mem_addr. mem_data_valid/mem_data is a one-cycle return. Returns
// come back in request order. Each accepted return is written into the arrays
// in the same cycle through purely combinational enables.
//
// Optional build macro: CRITICAL_WORD_FIRST_EN
//   When defined, the fetch starts at the missed word (miss_address[3:1]) and
//   wraps mod 8. An extra crit_word_valid output pulses on the first write.
//   When undefined, words are always fetched 0..7.
//
// dbg_state_o exposes the FSM state. Encoding: IDLE=0, REQ=1, WAIT=2,
// META=3, DONE=4.

module cache_fill_fsm #(
    parameter int WORDS = 8,
    parameter int SETS  = 64,
    parameter int TAG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [15:0]       miss_address,
    input  logic              victim_way,
    input  logic [7:0]        other_meta,
    output logic              mem_req,
    output logic [15:0]       mem_addr,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_data,
    output logic              fsm_busy,
    output logic [15:0]       DataIn,
    output logic              WriteEnable0,
    output logic              WriteEnable1,
    output logic [7:0]        MetaDataIn0,
    output logic [7:0]        MetaDataIn1,
    output logic              MetaDataWriteEnable0,
    output logic              MetaDataWriteEnable1,
    output logic [SETS-1:0]   BlockEnable,
    output logic [WORDS-1:0]  WordEnable,
    output logic              fill_done,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic              crit_word_valid,
`endif
    output logic [2:0]        dbg_state_o
);

    // Field widths of the 16-bit byte address: {tag, index, word, byte}.
    localparam int CNT_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);

    localparam logic [CNT_W-1:0] ISS_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W:0]   RX_LAST  = (CNT_W + 1)'(WORDS - 1);
    localparam logic [WORDS-1:0] WORD_ONE = WORDS'(1);
    localparam logic [SETS-1:0]  SET_ONE  = SETS'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_META = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   iss_cnt_q, iss_cnt_d;   // requests issued so far
    logic [CNT_W:0]     rx_cnt_q, rx_cnt_d;     // returns consumed; MSB = all done
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               victim_q, victim_d;
    logic [7:0]         other_meta_q, other_meta_d;
`ifdef CRITICAL_WORD_FIRST_EN
    logic [CNT_W-1:0]   w0_q, w0_d;             // critical (first fetched) word
`endif

    logic               rx_accept;              // a return is written this cycle
    logic               rx_last;                // ... and it is the final one
    logic               rx_full;                // all returns already consumed
    logic [CNT_W-1:0]   req_word;
    logic [CNT_W-1:0]   rx_word;

    // Byte offset bits and the old lru bit of the other way never matter.
    logic unused_bits;
    assign unused_bits = ^{miss_address[3:0], other_meta[6]};

    // Returns are only meaningful while the fill is collecting data, and
    // anything past the last word of the block is dropped.
    assign rx_full   = rx_cnt_q[CNT_W];
    assign rx_accept = mem_data_valid && !rx_full &&
                       ((state_q == S_REQ) || (state_q == S_WAIT));
    assign rx_last   = rx_accept && (rx_cnt_q == RX_LAST);

    // Word order: plain ascending, or rotated so the missed word comes first.
`ifdef CRITICAL_WORD_FIRST_EN
    assign req_word = w0_q + iss_cnt_q;
    assign rx_word  = w0_q + rx_cnt_q[CNT_W-1:0];
`else
    assign req_word = iss_cnt_q;
    assign rx_word  = rx_cnt_q[CNT_W-1:0];
`endif

    // State and latched miss context; reset aborts any fill in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            iss_cnt_q    <= '0;
            rx_cnt_q     <= '0;
            tag_q        <= '0;
            index_q      <= '0;
            victim_q     <= 1'b0;
            other_meta_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            w0_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            iss_cnt_q    <= iss_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            victim_q     <= victim_d;
            other_meta_q <= other_meta_d;
`ifdef CRITICAL_WORD_FIRST_EN
            w0_q         <= w0_d;
`endif
        end
    end

    // Next-state logic: latch on a miss in IDLE only, count requests and
    // returns, move to META once the final return has been written.
    always_comb begin
        state_d      = state_q;
        iss_cnt_d    = iss_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        tag_d        = tag_q;
        index_d      = index_q;
        victim_d     = victim_q;
        other_meta_d = other_meta_q;
`ifdef CRITICAL_WORD_FIRST_EN
        w0_d         = w0_q;
`endif

        if (rx_accept) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (miss_detected) begin
                    tag_d        = miss_address[15:16-TAG_W];
                    index_d      = miss_address[15-TAG_W:16-TAG_W-IDX_W];
                    victim_d     = victim_way;
                    other_meta_d = other_meta;
`ifdef CRITICAL_WORD_FIRST_EN
                    w0_d         = miss_address[CNT_W:1];
`endif
                    iss_cnt_d    = '0;
                    rx_cnt_d     = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                iss_cnt_d = iss_cnt_q + 1'b1;
                if (iss_cnt_q == ISS_LAST) begin
                    // Skip WAIT when the final return lands on the last request.
                    state_d = (rx_last || rx_full) ? S_META : S_WAIT;
                end
            end
            S_WAIT: begin
                if (rx_last || rx_full) begin
                    state_d = S_META;
                end
            end
            S_META: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Array-side and memory-side outputs, all decoded from the state and the
    // current return; everything is zero outside the cycles that use it.
    always_comb begin
        fsm_busy             = 1'b0;
        mem_req              = 1'b0;
        mem_addr             = '0;
        DataIn               = '0;
        WriteEnable0         = 1'b0;
        WriteEnable1         = 1'b0;
        WordEnable           = '0;
        MetaDataIn0          = '0;
        MetaDataIn1          = '0;
        MetaDataWriteEnable0 = 1'b0;
        MetaDataWriteEnable1 = 1'b0;
        BlockEnable          = '0;
        fill_done            = 1'b0;

        fsm_busy = (state_q == S_REQ) || (state_q == S_WAIT) ||
                   (state_q == S_META);

        if (fsm_busy) begin
            BlockEnable = SET_ONE << index_q;
        end

        if (state_q == S_REQ) begin
            mem_req  = 1'b1;
            mem_addr = {tag_q, index_q, req_word, 1'b0};
        end

        // Same-cycle data write into the victim way only.
        if (rx_accept) begin
            DataIn       = mem_data;
            WriteEnable0 = !victim_q;
            WriteEnable1 = victim_q;
            WordEnable   = WORD_ONE << rx_word;
        end

        // Victim becomes valid/MRU with the new tag; the other way keeps its
        // valid bit and tag but is marked LRU.
        if (state_q == S_META) begin
            MetaDataWriteEnable0 = 1'b1;
            MetaDataWriteEnable1 = 1'b1;
            if (victim_q) begin
                MetaDataIn1 = {1'b1, 1'b0, tag_q};
                MetaDataIn0 = {other_meta_q[7], 1'b1, other_meta_q[5:0]};
            end else begin
                MetaDataIn0 = {1'b1, 1'b0, tag_q};
                MetaDataIn1 = {other_meta_q[7], 1'b1, other_meta_q[5:0]};
            end
        end

        if (state_q == S_DONE) begin
            fill_done = 1'b1;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    // The first write of a fill always carries the missed word.
    assign crit_word_valid = rx_accept && (rx_cnt_q == '0);
`endif

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed testbench for cache_fill_fsm. Each fill is driven cycle by cycle
// with a hand-derived schedule: miss in cycle 0, request k in cycle 1+k,
// return i in cycle 1+lat+gap*i, META one cycle after the last return and
// fill_done one cycle after that.

module tb_cache_fill_fsm;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_detected = 1'b0;
    logic [15:0]  miss_address = '0;
    logic         victim_way = 1'b0;
    logic [7:0]   other_meta = '0;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_data_valid = 1'b0;
    logic [15:0]  mem_data = '0;
    logic         fsm_busy;
    logic [15:0]  DataIn;
    logic         WriteEnable0, WriteEnable1;
    logic [7:0]   MetaDataIn0, MetaDataIn1;
    logic         MetaDataWriteEnable0, MetaDataWriteEnable1;
    logic [63:0]  BlockEnable;
    logic [7:0]   WordEnable;
    logic         fill_done;
`ifdef CRITICAL_WORD_FIRST_EN
    logic         crit_word_valid;
`endif
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    cache_fill_fsm dut (
        .clk                  (clk),
        .rst                  (rst),
        .miss_detected        (miss_detected),
        .miss_address         (miss_address),
        .victim_way           (victim_way),
        .other_meta           (other_meta),
        .mem_req              (mem_req),
        .mem_addr             (mem_addr),
        .mem_data_valid       (mem_data_valid),
        .mem_data             (mem_data),
        .fsm_busy             (fsm_busy),
        .DataIn               (DataIn),
        .WriteEnable0         (WriteEnable0),
        .WriteEnable1         (WriteEnable1),
        .MetaDataIn0          (MetaDataIn0),
        .MetaDataIn1          (MetaDataIn1),
        .MetaDataWriteEnable0 (MetaDataWriteEnable0),
        .MetaDataWriteEnable1 (MetaDataWriteEnable1),
        .BlockEnable          (BlockEnable),
        .WordEnable           (WordEnable),
        .fill_done            (fill_done),
`ifdef CRITICAL_WORD_FIRST_EN
        .crit_word_valid      (crit_word_valid),
`endif
        .dbg_state_o          (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Everything the block drives must be zero while idle or in reset.
    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  64'(fsm_busy), 64'd0);
        chk({tag, "_req"},   64'(mem_req), 64'd0);
        chk({tag, "_addr"},  64'(mem_addr), 64'd0);
        chk({tag, "_din"},   64'(DataIn), 64'd0);
        chk({tag, "_we0"},   64'(WriteEnable0), 64'd0);
        chk({tag, "_we1"},   64'(WriteEnable1), 64'd0);
        chk({tag, "_md0"},   64'(MetaDataIn0), 64'd0);
        chk({tag, "_md1"},   64'(MetaDataIn1), 64'd0);
        chk({tag, "_mwe0"},  64'(MetaDataWriteEnable0), 64'd0);
        chk({tag, "_mwe1"},  64'(MetaDataWriteEnable1), 64'd0);
        chk({tag, "_blk"},   BlockEnable, 64'd0);
        chk({tag, "_wen"},   64'(WordEnable), 64'd0);
        chk({tag, "_done"},  64'(fill_done), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'd0);
`ifdef CRITICAL_WORD_FIRST_EN
        chk({tag, "_crit"},  64'(crit_word_valid), 64'd0);
`endif
    endtask

    // Drive one complete fill and check every output in every cycle.
    // After the miss cycle the miss inputs are scrambled to catch re-latching.
    task automatic run_fill(input string tag, input logic [15:0] addr,
                            input logic victim, input logic [7:0] om,
                            input int lat, input int gap,
                            input logic [7:0] exp_meta_v, input logic [7:0] exp_meta_o,
                            input logic hold_miss, input logic extra_rx);
        logic [2:0]  w0;
        logic [2:0]  wrd;
        logic [63:0] blk;
        logic [15:0] dat;
        logic        busy_e, req_e, meta_e;
        int          r0, rlast, rx_i;
        w0 = 3'd0;
`ifdef CRITICAL_WORD_FIRST_EN
        w0 = addr[3:1];
`endif
        blk   = 64'd1 << addr[9:4];
        r0    = 1 + lat;
        rlast = r0 + 7 * gap;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(16'h3C00 + addr[15:8] + i * 16'h0111));
        for (int c = 0; c <= rlast + 3; c++) begin
            miss_detected  = (c == 0) || (hold_miss && c <= rlast + 2);
            miss_address   = (c == 0) ? addr : 16'hFFFF;
            victim_way     = (c == 0) ? victim : ~victim;
            other_meta     = (c == 0) ? om : ~om;
            mem_data_valid = 1'b0;
            mem_data       = 16'hDEAD;
            dat            = 16'h0000;
            rx_i           = -1;
            if (c >= r0 && c <= rlast && ((c - r0) % gap) == 0) begin
                rx_i           = (c - r0) / gap;
                dat            = exp_q.pop_front();
                mem_data_valid = 1'b1;
                mem_data       = dat;
            end
            if (extra_rx && c == rlast + 1) begin
                mem_data_valid = 1'b1;
                mem_data       = 16'hBAD0;
            end
            #1;
            busy_e = (c >= 1 && c <= rlast + 1);
            req_e  = (c >= 1 && c <= 8);
            meta_e = (c == rlast + 1);
            wrd    = w0 + 3'(c - 1);
            chk({tag, "_busy"}, 64'(fsm_busy), 64'(busy_e));
            chk({tag, "_req"},  64'(mem_req), 64'(req_e));
            chk({tag, "_addr"}, 64'(mem_addr), req_e ? 64'({addr[15:4], wrd, 1'b0}) : 64'd0);
            chk({tag, "_blk"},  BlockEnable, busy_e ? blk : 64'd0);
            chk({tag, "_we0"},  64'(WriteEnable0), 64'(rx_i >= 0 && !victim));
            chk({tag, "_we1"},  64'(WriteEnable1), 64'(rx_i >= 0 && victim));
            chk({tag, "_wen"},  64'(WordEnable), (rx_i >= 0) ? (64'd1 << (w0 + 3'(rx_i))) : 64'd0);
            chk({tag, "_din"},  64'(DataIn), 64'(dat));
            chk({tag, "_mwe0"}, 64'(MetaDataWriteEnable0), 64'(meta_e));
            chk({tag, "_mwe1"}, 64'(MetaDataWriteEnable1), 64'(meta_e));
            chk({tag, "_md0"},  64'(MetaDataIn0), meta_e ? 64'(victim ? exp_meta_o : exp_meta_v) : 64'd0);
            chk({tag, "_md1"},  64'(MetaDataIn1), meta_e ? 64'(victim ? exp_meta_v : exp_meta_o) : 64'd0);
            chk({tag, "_done"}, 64'(fill_done), 64'(c == rlast + 2));
`ifdef CRITICAL_WORD_FIRST_EN
            chk({tag, "_crit"}, 64'(crit_word_valid), 64'(rx_i == 0));
`endif
            tick();
        end
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
        #1;
        check_idle({tag, "_after"});
        tick();
    endtask

    initial begin
        // Reset and idle with reset held
        #3 rst = 1'b0;
        #1 check_idle("rst_async");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("rst_idle");
        end
        // Release reset away from the clock edge; no spurious enables
        #3 rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 check_idle("idle_after_rst");
            tick();
        end

        // Basic fill: victim way 1, latency 1, done in cycle 11
        // tag=0x29 index=27 -> victim meta 0xA9, other 0x85 -> 0xC5
        run_fill("fill_lat1", 16'hA5B6, 1'b1, 8'h85, 1, 1, 8'hA9, 8'hC5, 1'b0, 1'b0);

        // Latency 4 with a bubble between returns; META only after 8th write
        // 0x7F02: tag=0x1F -> 0x9F; other 0x00 -> 0x40
        run_fill("fill_lat4", 16'h7F02, 1'b0, 8'h00, 4, 2, 8'h9F, 8'h40, 1'b0, 1'b0);

        // Return arriving in IDLE writes nothing and is not counted
        mem_data_valid = 1'b1;
        mem_data       = 16'hBEEF;
        #1 check_idle("valid_in_idle");
        tick();
        mem_data_valid = 1'b0;
        #1 check_idle("idle_after_pulse");
        tick();

        // Miss held high through the fill plus a 9th return during META
        // 0x123E: tag=0x04 -> 0x84; other 0x3F -> 0x7F
        run_fill("fill_hold", 16'h123E, 1'b0, 8'h3F, 1, 1, 8'h84, 8'h7F, 1'b1, 1'b1);
        #1 check_idle("hold_settled");
        tick();

        // Reset after the third data write aborts the fill
        // 0x4C20: tag=0x13 -> 0x93; index 2; other 0x40 -> 0x40
        for (int c = 0; c <= 4; c++) begin
            miss_detected  = (c == 0);
            miss_address   = 16'h4C20;
            victim_way     = 1'b0;
            other_meta     = 8'h40;
            mem_data_valid = (c >= 2);
            mem_data       = 16'(16'h7700 + c);
            #1;
            chk("abort_we0", 64'(WriteEnable0), 64'(c >= 2));
            chk("abort_wen", 64'(WordEnable), (c >= 2) ? (64'd1 << (c - 2)) : 64'd0);
            chk("abort_blk", BlockEnable, (c >= 1) ? 64'h4 : 64'd0);
            tick();
        end
        mem_data_valid = 1'b1;
        #1 rst = 1'b0;
        #1 check_idle("abort_now");
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle("abort_hold");
        end
        #2 rst = 1'b1;
        mem_data_valid = 1'b0;
        #1 check_idle("abort_release");
        tick();
        run_fill("fill_fresh", 16'h4C20, 1'b0, 8'h40, 1, 1, 8'h93, 8'h40, 1'b0, 1'b0);

`ifdef CRITICAL_WORD_FIRST_EN
        // Critical word first: word 3 first, wrap to word 0 after word 7
        // 0x0016: tag=0 -> 0x80; other 0xFF -> 0xFF
        run_fill("fill_cwf", 16'h0016, 1'b1, 8'hFF, 1, 1, 8'h80, 8'hFF, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler and fill engine driving the write side of the 2-way, 64-set, 8-word-per-block cache storage (data arrays plus metadata arrays).
- On a miss it issues 8 sequential word reads to main memory and writes each returned word into the victim way.
- It then writes the victim tag/valid/LRU byte and updates the LRU bit of the other way.
- Sits between the cache-hit logic and the memory; acts as the initiator towards the cache arrays.

Parameters:
- WORDS, 8, words per block; must match the 8-bit WordEnable of the arrays.
- SETS, 64, number of sets; must match the 64-bit BlockEnable of the arrays.
- TAG_W, 6, tag width; derived from the 16-bit byte address as addr[15:10].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- miss_detected  in  1  level; a miss is pending on miss_address.
- miss_address  in  16  byte address. Fields: tag [15:10], index [9:4], word [3:1], byte [0].
- victim_way  in  1  way to fill; sampled with the miss.
- other_meta  in  8  current metadata byte of the non-victim way; sampled with the miss.
- mem_req  out  1  one-cycle read request to memory.
- mem_addr  out  16  word-aligned request address.
- mem_data_valid  in  1  a returned word is present. Returns arrive in request order, latency ≥1.
- mem_data  in  16  returned word.
- fsm_busy  out  1  fill in progress; the external mux gives the array enables to this block when high.
- DataIn  out  16  write data to both data arrays.
- WriteEnable0, WriteEnable1  out  1 each  per-way data write enables.
- MetaDataIn0, MetaDataIn1  out  8 each  metadata write values.
- MetaDataWriteEnable0, MetaDataWriteEnable1  out  1 each  per-way metadata write enables.
- BlockEnable  out  64  one-hot set select.
- WordEnable  out  8  one-hot word select.
- fill_done  out  1  one-cycle pulse when the fill completes.

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0, all outputs 0.
- Metadata byte format: {valid[7], lru[6], tag[5:0]}. lru=1 means least recently used.
- States:
  - IDLE -> REQ when miss_detected=1. Latch tag, index, victim_way and other_meta. fsm_busy=1 from the next cycle.
  - REQ: mem_req=1 every cycle for 8 cycles. mem_addr={tag,index,iss_cnt[2:0],1'b0}, iss_cnt 0..7. After iss_cnt=7 -> WAIT.
  - WAIT: hold until all returns are consumed, then -> META.
  - Returns are accepted in REQ and WAIT. Each mem_data_valid=1 produces a same-cycle combinational write:
    - DataIn=mem_data.
    - WriteEnable[victim]=1; the other way's WriteEnable=0.
    - WordEnable=1<<rx_cnt.
    - rx_cnt increments.
    - After the 8th return, next state is META (directly from REQ if the 8th return lands there).
  - META (1 cycle): MetaDataWriteEnable0=MetaDataWriteEnable1=1.
    - MetaDataIn[victim]={1,0,tag}.
    - MetaDataIn[other]={other_meta[7],1,other_meta[5:0]}.
    - -> DONE.
  - DONE (1 cycle): fill_done=1, fsm_busy=0 -> IDLE.
- BlockEnable=1<<index whenever fsm_busy=1; 0 otherwise.
- WordEnable is 0 except during data write cycles.
- Minimum fill latency with 1-cycle memory: miss at cycle 0, done pulse at cycle 11.
- Boundary conditions:
  - miss_detected while busy or in DONE: ignored; no re-latch.
  - mem_data_valid in IDLE, META or DONE: ignored, no write.
  - Returns beyond the 8th: ignored.
  - miss_address[3:0] is ignored for fetch order (block-aligned fill).
  - Reset mid-fill aborts the fill: no further write enables, and no metadata write.
  - No write enable is ever asserted for both ways in the same data cycle.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - Requests start at word w0=miss_address[3:1] and wrap mod 8: word index=(w0+iss_cnt)&7.
  - WordEnable follows the same rotation: (w0+rx_cnt)&7.
  - An extra output crit_word_valid (1 bit) pulses on the first data write cycle.
- Undefined:
  - Order is always 0..7.
  - crit_word_valid is absent.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0 and fsm_busy=0. Deassert rst mid-idle -> no spurious enables.
- miss_address=0xA5B6, victim_way=1, other_meta=0x85, memory latency 1 ->
  - mem_addr 0xA5B0, 0xA5B2 .. 0xA5BE on 8 consecutive cycles.
  - WriteEnable1 writes 8 words with WordEnable 0x01..0x80.
  - BlockEnable=1<<27.
  - META cycle: MetaDataIn1=0xA9, MetaDataIn0=0xC5.
  - fill_done at cycle 11.
- Memory latency 4 with bubbles (valid every other cycle) -> still exactly 8 writes in order, and META only after the 8th.
- miss_detected held high through the fill and mem_data_valid pulsed in IDLE -> single fill, no writes in IDLE, returns to IDLE after fill_done.
- rst asserted after the 3rd data write -> outputs clear immediately, and neither MetaDataWriteEnable rises. The next miss starts a fresh fill at word 0.
- With CRITICAL_WORD_FIRST_EN and miss_address=0x0016 ->
  - mem_addr order 0x0016, 0x0018 .. 0x001E, 0x0010 .. 0x0014.
  - crit_word_valid pulses on the first write, with WordEnable=0x08.
